// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC packet layout and sizing, used by the arbiter and the PEs.
package noc_pkg;
    localparam int NUM_PORTS   = 4;
    localparam int PKT_W       = 8;
    localparam int SRC_W       = 2;
    localparam int SRC_MSB     = 7;
    localparam int SRC_LSB     = 6;
    localparam int DEST_MSB    = 5;
    localparam int DEST_LSB    = 4;
    localparam int PAYLOAD_MSB = 3;
    localparam int PAYLOAD_LSB = 0;

    typedef struct packed {
        logic [SRC_MSB-SRC_LSB:0]         src;
        logic [DEST_MSB-DEST_LSB:0]       dest;
        logic [PAYLOAD_MSB:PAYLOAD_LSB]   payload;
    } pkt_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker; scans upward from last+1.
module rr_pick
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SRC_W-1:0]     last,
    output logic [NUM_PORTS-1:0] grant,
    output logic [SRC_W-1:0]     idx,
    output logic                 any
);
    logic [SRC_W-1:0] p;

    always_comb begin
        grant = '0;
        idx   = last;
        any   = 1'b0;
        p     = last;
        // Offset NUM_PORTS wraps back to last itself, so it has lowest priority.
        for (int k = 1; k <= NUM_PORTS; k++) begin
            p = last + SRC_W'(k);
            if (!any && req[p]) begin
                any      = 1'b1;
                idx      = p;
                grant[p] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter: round-robin N:1 packet arbiter into a shared FIFO with source check.
// Optional NOC_ARB_STATS_EN adds per-port good-grant counters (stat_sel/stat_count).
module noc_rr_arbiter #(
    parameter int NUM_PORTS = noc_pkg::NUM_PORTS,
    parameter int PKT_W     = noc_pkg::PKT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PORTS-1:0]       req_valid,
    input  logic [NUM_PORTS*PKT_W-1:0] req_packet,
    output logic [NUM_PORTS-1:0]       req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [PKT_W-1:0]           fifo_packet,
    output logic                       src_err,
    output logic [7:0]                 err_count,
    output logic                       busy
`ifdef NOC_ARB_STATS_EN
    ,
    input  logic [1:0]                 stat_sel,
    output logic [7:0]                 stat_count
`endif
);
    logic                         out_valid;
    logic [PKT_W-1:0]             out_pkt;
    logic [noc_pkg::SRC_W-1:0]    last_grant, win_idx;
    logic [NUM_PORTS-1:0]         win;
    logic                         win_any, accept_ok, hs, src_ok;
    noc_pkg::pkt_t                win_pkt;

    rr_pick u_pick (
        .req   (req_valid),
        .last  (last_grant),
        .grant (win),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign fifo_wr_en  = out_valid && !fifo_full;
    assign fifo_packet = out_pkt;
    assign accept_ok   = !out_valid || fifo_wr_en;
    assign req_ready   = accept_ok ? win : '0;
    assign hs          = win_any && accept_ok;
    assign win_pkt     = req_packet[win_idx*PKT_W +: PKT_W];
    assign src_ok      = win_pkt.src == win_idx;
    assign busy        = out_valid || |req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_pkt    <= '0;
            last_grant <= '1;
            src_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            if (hs) last_grant <= win_idx;
            src_err <= hs && !src_ok;
            if (hs && !src_ok && err_count != 8'hFF) err_count <= err_count + 8'd1;
            // A same-cycle good handshake reloads the buffer as it drains.
            if (hs && src_ok) begin
                out_valid <= 1'b1;
                out_pkt   <= win_pkt;
            end else if (fifo_wr_en) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef NOC_ARB_STATS_EN
    logic [7:0] stat_cnt [NUM_PORTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) stat_cnt[i] <= '0;
        end else if (hs && src_ok && stat_cnt[win_idx] != 8'hFF) begin
            stat_cnt[win_idx] <= stat_cnt[win_idx] + 8'd1;
        end
    end

    assign stat_count = stat_cnt[stat_sel];
`endif
endmodule

// File: tb/tb_noc_rr_arbiter.sv
// tb_noc_rr_arbiter: directed-vector bench for noc_rr_arbiter.
module tb_noc_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_packet;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_packet;
    logic        src_err;
    logic [7:0]  err_count;
    logic        busy;
`ifdef NOC_ARB_STATS_EN
    logic [1:0]  stat_sel;
    logic [7:0]  stat_count;
`endif

    int n_run  = 0;
    int n_fail = 0;
    logic [7:0] pk [4] = '{8'h05, 8'h4A, 8'h83, 8'hCF};

    noc_rr_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_packet  (req_packet),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_packet (fifo_packet),
        .src_err     (src_err),
        .err_count   (err_count),
        .busy        (busy)
`ifdef NOC_ARB_STATS_EN
        ,
        .stat_sel    (stat_sel),
        .stat_count  (stat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_packet = {8'hCF, 8'h83, 8'h4A, 8'h05};
        fifo_full  = 1'b0;
`ifdef NOC_ARB_STATS_EN
        stat_sel   = 2'd0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_src_err", src_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_pkt", fifo_packet, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // all four ports valid: grants 0,1,2,3,0 and one write per cycle
        @(negedge clk);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", req_ready, 4'b0001 << (k % 4));
            chk("rr_wr_en", fifo_wr_en, k > 0);
            if (k > 0) chk("rr_pkt", fifo_packet, pk[(k-1)%4]);
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        chk("rr_tail_wr_en", fifo_wr_en, 1);
        chk("rr_tail_pkt", fifo_packet, 8'h05);
        chk("rr_tail_ready", req_ready, 0);
        @(negedge clk);
        chk("rr_idle_wr_en", fifo_wr_en, 0);
        chk("rr_idle_busy", busy, 0);

        // port 1 packet held while fifo full; port 3 waits
        req_valid = 4'b0010;
        fifo_full = 1'b1;
        #1;
        chk("full_first_ready", req_ready, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'b1000;
            #1;
            chk("full_wr_en", fifo_wr_en, 0);
            chk("full_pkt", fifo_packet, 8'h4A);
            chk("full_ready", req_ready, 0);
        end
        @(negedge clk);
        fifo_full = 1'b0;
        #1;
        chk("unfull_wr_en", fifo_wr_en, 1);
        chk("unfull_pkt", fifo_packet, 8'h4A);
        chk("unfull_ready", req_ready, 4'b1000);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("unfull_next_pkt", fifo_packet, 8'hCF);
        chk("unfull_next_wr_en", fifo_wr_en, 1);
        @(negedge clk);
        chk("unfull_idle", fifo_wr_en, 0);

        // port 2 sends src=1: dropped
        req_packet[23:16] = 8'h47;
        req_valid = 4'b0100;
        #1;
        chk("drop_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("drop_src_err", src_err, 1);
        chk("drop_wr_en", fifo_wr_en, 0);
        chk("drop_err_count", err_count, 1);
        @(negedge clk);
        chk("drop_src_err_clr", src_err, 0);
        chk("drop_wr_en2", fifo_wr_en, 0);

        // 300 mismatched packets from port 0
        req_packet[7:0] = 8'hC0;
        req_valid = 4'b0001;
        repeat (100) @(negedge clk);
        chk("sat_mid_count", err_count, 101);
        chk("sat_mid_src_err", src_err, 1);
        chk("sat_mid_wr_en", fifo_wr_en, 0);
        repeat (200) @(negedge clk);
        req_valid = '0;
        chk("sat_count", err_count, 255);
        @(negedge clk);
        chk("sat_hold", err_count, 255);

        // reset while 0x83 is buffered
        req_packet = {8'hCF, 8'h83, 8'h4A, 8'h05};
        req_valid = 4'b0100;
        fifo_full = 1'b1;
        #1;
        chk("rstmid_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("rstmid_pkt", fifo_packet, 8'h83);
        chk("rstmid_wr_en", fifo_wr_en, 0);
        rst_n = 1'b0;
        fifo_full = 1'b0;
        #1;
        chk("rstmid_wr_en_rst", fifo_wr_en, 0);
        chk("rstmid_pkt_rst", fifo_packet, 0);
        chk("rstmid_err_rst", err_count, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_wr_en_hold", fifo_wr_en, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_after_wr_en", fifo_wr_en, 0);
        req_valid = 4'hF;
        #1;
        chk("rstmid_first_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("rstmid_new_pkt", fifo_packet, 8'h05);
        chk("rstmid_new_wr_en", fifo_wr_en, 1);
        @(negedge clk);

`ifdef NOC_ARB_STATS_EN
        stat_sel = 2'd2;
        req_valid = 4'b0100;
        repeat (3) @(negedge clk);
        req_valid = '0;
        #1;
        chk("stat_port2", stat_count, 3);
        stat_sel = 2'd0;
        #1;
        chk("stat_port0", stat_count, 1);
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/noc_rr_arbiter.md
NOC_RR_ARBITER -- requirements
Module: noc_rr_arbiter

Interface
REQ-001 Parameter: NUM_PORTS, 4, requester count; fixed by the 2-bit src_id field.
REQ-002 Parameter: PKT_W, 8, packet width {src[7:6], dest[5:4], payload[3:0]}.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NUM_PORTS  per-PE packet offer.
REQ-006 req_packet  input  NUM_PORTS*PKT_W  packets; port i at bits [8i+7:8i].
REQ-007 req_ready  output  NUM_PORTS  one-hot grant; transfer on valid&&ready.
REQ-008 fifo_full  input  1  shared FIFO full.
REQ-009 fifo_wr_en  output  1  write strobe to shared FIFO.
REQ-010 fifo_packet  output  PKT_W  packet to shared FIFO.
REQ-011 src_err  output  1  one-cycle pulse when a packet is dropped for src mismatch.
REQ-012 err_count  output  8  saturating count of dropped packets.
REQ-013 busy  output  1  high while out_valid or any req_valid.

Function
REQ-014 Single output register (out_pkt, out_valid) shall form the only packet buffer.
REQ-015 fifo_wr_en SHALL equal out_valid && !fifo_full (combinational); fifo_packet SHALL equal out_pkt.
REQ-016 Arbiter SHALL accept when accept_ok = !out_valid || fifo_wr_en; no grant otherwise.
REQ-017 Winner: first requesting port scanning from (last_grant+1) mod 4 upward; last_grant updates only on a completed handshake.
REQ-018 req_ready SHALL be combinational, one-hot, only for the winner, only when accept_ok; zero when no request.
REQ-019 Handshake with packet[7:6]==port index SHALL load out_pkt and set out_valid next cycle.
REQ-020 Handshake with packet[7:6]!=port index SHALL consume and drop the packet: out_valid unchanged by it, src_err pulses next cycle, err_count increments, saturating at 255.
REQ-021 Latency: accepted packet on fifo_wr_en the cycle after handshake if fifo_full low; full throughput of one packet per cycle.
REQ-022 fifo_full high: out_pkt held stable, fifo_wr_en low, all req_ready low until full drops.
REQ-023 out_valid clears after fifo_wr_en unless same-cycle handshake reloads it.
REQ-024 Requester deasserting req_valid before grant SHALL lose nothing; last_grant unchanged.
REQ-025 Fairness: with all four ports continuously valid, grant order 0,1,2,3,0,... after reset.

Reset
REQ-026 rst_n low: out_valid=0, out_pkt=0, last_grant=3 (so port 0 first), src_err=0, err_count=0; hence fifo_wr_en=0, req_ready=0.
REQ-027 Reset mid-transfer SHALL discard buffered packet; no fifo_wr_en until a new handshake after deassertion.

Configuration
REQ-028 Macro NOC_ARB_STATS_EN defined: adds input stat_sel[1:0] and output stat_count[7:0] = saturating per-port count of valid (non-dropped) grants, reset to 0.
REQ-029 Without NOC_ARB_STATS_EN: ports and counters absent; all other behaviour identical.

Structure
REQ-030 Shared package noc_pkg SHALL hold PKT_W, NUM_PORTS, field offsets (SRC_MSB/LSB, DEST_MSB/LSB, PAYLOAD_MSB/LSB) and packet field typedef, reused by the PE.
REQ-031 Sub-module rr_pick (combinational rotating-priority picker: req vector, last_grant -> one-hot grant, index, any) SHALL be instantiated once.

Verification
REQ-032 Ports 0-3 valid, fifo_full=0, packets 0x05,0x4A,0x83,0xCF -> fifo_packet 0x05,0x4A,0x83,0xCF on 4 consecutive cycles, req_ready 0001,0010,0100,1000.
REQ-033 Port 1 sends 0x4A, fifo_full=1 for 3 cycles -> fifo_packet 0x4A held, fifo_wr_en=0, req_ready=0 for 3 cycles, write on 4th.
REQ-034 Port 2 sends 0x47 (src=1) -> dropped, no fifo_wr_en, src_err one pulse, err_count=1.
REQ-035 300 mismatched packets -> err_count saturates at 255.
REQ-036 rst_n low while out_valid=1 with 0x83 -> fifo_wr_en never asserts 0x83; after release first grant is port 0.
REQ-037 With NOC_ARB_STATS_EN, 3 good grants to port 2, stat_sel=2 -> stat_count=3.
